// File: rtl/image_frame_uart_tx.sv
// Streams START_CHAR, W*H row-major pixels from a 1-cycle RAM, then STOP_CHAR into a UART TX FIFO. Optional `FRAME_CLAMP_EN remaps marker-valued pixels.
// Latency: 3*W*H+4 cycles from the frame_start cycle to frame_done when tx_full stays low.
// Backpressure: SEND states hold while tx_full. Pushes are spaced >=2 cycles so tx_full always reflects the last push.
module image_frame_uart_tx #(
  parameter int          IMAGE_WIDTH = 8,
  parameter int          IMAGE_HIGHT = 8,
  parameter int          DATA_WIDTH  = 8,
  parameter logic [7:0]  START_CHAR  = 8'd90,
  parameter logic [7:0]  STOP_CHAR   = 8'd90,
  parameter int          ADDR_WIDTH  = $clog2(IMAGE_WIDTH*IMAGE_HIGHT)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  frame_start,
  input  logic                  abort,
  output logic                  pix_rd_en,
  output logic [ADDR_WIDTH-1:0] pix_addr,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  tx_full,
  output logic                  write_uart,
  output logic [7:0]            tx_data,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic [2:0]            state
);

  localparam int unsigned NPIX = IMAGE_WIDTH * IMAGE_HIGHT;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND_START = 3'd1,
    FETCH      = 3'd2,
    WAIT_DATA  = 3'd3,
    SEND_PIX   = 3'd4,
    SEND_STOP  = 3'd5,
    DONE       = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pix_addr_q, pix_addr_d;
  logic [DATA_WIDTH-1:0]   pix_q;
  logic                    write_uart_q;
  logic [7:0]              tx_data_q;
  logic                    pix_rd_en_q;
  logic                    frame_busy_q;
  logic                    frame_done_q;
  logic                    push;
  logic [7:0]              push_byte;
  logic                    can_push;

  function automatic logic [7:0] payload_byte(input logic [7:0] px);
    logic [7:0] r;
    r = px;
`ifdef FRAME_CLAMP_EN
    // Keep marker values out of the payload so the receiver can resync on them.
    if (px == START_CHAR) begin
      r = (START_CHAR == 8'd0) ? 8'd1 : START_CHAR - 8'd1;
    end else if (px == STOP_CHAR) begin
      r = (STOP_CHAR == 8'd0) ? 8'd1 : STOP_CHAR - 8'd1;
    end
`endif
    return r;
  endfunction

  // No push in the cycle right after a push: tx_full would not yet include it.
  assign can_push = !tx_full && !write_uart_q;

  always_comb begin
    state_d    = state_q;
    pix_addr_d = pix_addr_q;
    push       = 1'b0;
    push_byte  = 8'd0;
    case (state_q)
      IDLE: begin
        pix_addr_d = '0;
        if (frame_start && !abort) begin
          state_d = SEND_START;
        end
      end
      SEND_START: begin
        if (can_push) begin
          push      = 1'b1;
          push_byte = START_CHAR;
          state_d   = FETCH;
        end
      end
      FETCH:     state_d = WAIT_DATA;
      WAIT_DATA: state_d = SEND_PIX;
      SEND_PIX: begin
        if (can_push) begin
          push      = 1'b1;
          push_byte = payload_byte(8'(pix_q));
          if (pix_addr_q == LAST_ADDR) begin
            pix_addr_d = '0;
            state_d    = SEND_STOP;
          end else begin
            pix_addr_d = pix_addr_q + ADDR_WIDTH'(1);
            state_d    = FETCH;
          end
        end
      end
      SEND_STOP: begin
        if (can_push) begin
          push      = 1'b1;
          push_byte = STOP_CHAR;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      pix_addr_d = '0;
      push       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pix_addr_q   <= '0;
      pix_q        <= '0;
      write_uart_q <= 1'b0;
      tx_data_q    <= 8'd0;
      pix_rd_en_q  <= 1'b0;
      frame_busy_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_addr_q   <= pix_addr_d;
      write_uart_q <= push;
      if (push) begin
        tx_data_q <= push_byte;
      end
      // RAM data arrives during WAIT_DATA, since the read strobe is high throughout FETCH.
      if (state_q == WAIT_DATA) begin
        pix_q <= pix_data;
      end
      pix_rd_en_q  <= (state_d == FETCH);
      frame_busy_q <= (state_d != IDLE);
      frame_done_q <= (state_d == DONE);
    end
  end

  assign pix_rd_en  = pix_rd_en_q;
  assign pix_addr   = pix_addr_q;
  assign write_uart = write_uart_q;
  assign tx_data    = tx_data_q;
  assign frame_busy = frame_busy_q;
  assign frame_done = frame_done_q;
  assign state      = state_q;

endmodule

// File: tb/tb_image_frame_uart_tx.sv
// Directed bench for image_frame_uart_tx: frame scenario table plus abort/reset sequences.
module tb_image_frame_uart_tx;

  localparam int NPIX = 64;
  localparam logic [7:0] MARK = 8'd90;
`ifdef FRAME_CLAMP_EN
  localparam logic [7:0] CLAMP_EXP = 8'd89;
`else
  localparam logic [7:0] CLAMP_EXP = 8'd90;
`endif

  typedef struct {
    int pattern;
    int stall_pix;
    int stall_len;
    bit repulse;
    int exp_lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       abort = 1'b0;
  logic       tx_full = 1'b0;
  logic       pix_rd_en;
  logic [5:0] pix_addr;
  logic [7:0] pix_data = 8'd0;
  logic       write_uart;
  logic [7:0] tx_data;
  logic       frame_busy;
  logic       frame_done;
  logic [2:0] state;

  logic [7:0] mem [NPIX];
  logic [7:0] rx_q [$];
  int         done_cnt = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  vec_t       vecs [6];

  always #5 clk = ~clk;

  image_frame_uart_tx dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .abort(abort),
    .pix_rd_en(pix_rd_en), .pix_addr(pix_addr), .pix_data(pix_data),
    .tx_full(tx_full), .write_uart(write_uart), .tx_data(tx_data),
    .frame_busy(frame_busy), .frame_done(frame_done), .state(state)
  );

  always @(posedge clk) if (pix_rd_en) pix_data <= mem[pix_addr];

  always @(negedge clk) begin
    if (write_uart) rx_q.push_back(tx_data);
    if (frame_done) done_cnt++;
  end

  function automatic logic [7:0] exp_pix(input logic [7:0] v);
`ifdef FRAME_CLAMP_EN
    if (v == MARK) return MARK - 8'd1;
`endif
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int pattern);
    for (int a = 0; a < NPIX; a++) begin
      case (pattern)
        1:       mem[a] = 8'(255 - a);
        2:       mem[a] = 8'(a * 3);
        3:       mem[a] = MARK;
        default: mem[a] = 8'(a);
      endcase
    end
    if (pattern == 4) mem[7] = MARK;
  endtask

  task automatic run_frame(input vec_t v);
    int cyc, stall_cnt, viol;
    bit got, stalled, rp_done;
    logic [7:0] e;
    fill(v.pattern);
    rx_q.delete();
    done_cnt = 0; cyc = 0; stall_cnt = 0; viol = 0;
    got = 0; stalled = 0; rp_done = 0;
    frame_start = 1'b1;
    while (!got && cyc < 2000) begin
      tick();
      cyc++;
      frame_start = 1'b0;
      if (v.repulse && !rp_done && state == 3'd4 && pix_addr == 6'd5) begin
        frame_start = 1'b1;
        rp_done = 1;
      end
      if (tx_full) begin
        stall_cnt++;
        if (write_uart) viol++;
        if (stall_cnt == v.stall_len) tx_full = 1'b0;
      end else if (v.stall_len > 0 && !stalled && state == 3'd4 && pix_addr == 6'(v.stall_pix)) begin
        tx_full = 1'b1;
        stalled = 1;
        stall_cnt = 0;
      end
      if (frame_done) got = 1;
    end
    check("latency", got ? cyc : 0, v.exp_lat);
    check("done_state", 32'(state), 6);
    if (v.repulse) frame_start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      frame_start = 1'b0;
    end
    tx_full = 1'b0;
    check("stall_push", viol, 0);
    check("done_count", done_cnt, 1);
    check("push_count", rx_q.size(), 66);
    check("end_idle", 32'({frame_busy, state, pix_addr}), 0);
    for (int i = 0; i < rx_q.size() && i < 66; i++) begin
      if (i == 0 || i == 65) e = MARK;
      else e = exp_pix(mem[i-1]);
      check($sformatf("byte%0d", i), 32'(rx_q[i]), 32'(e));
    end
    if (v.pattern == 4 && rx_q.size() > 8) check("clamp_byte8", 32'(rx_q[8]), 32'(CLAMP_EXP));
  endtask

  initial begin
    int wu, busy, guard;
    vecs[0] = '{0, -1, 0, 1'b0, 196};
    vecs[1] = '{0, 10, 20, 1'b0, 216};
    vecs[2] = '{1, 0, 5, 1'b0, 201};
    vecs[3] = '{2, -1, 0, 1'b1, 196};
    vecs[4] = '{3, 63, 1, 1'b0, 197};
    vecs[5] = '{4, -1, 0, 1'b0, 196};
    fill(0);

    // Reset and idle
    #1 reset_n = 1'b0;
    #1;
    check("reset_outs", 32'({pix_rd_en, pix_addr, write_uart, tx_data, frame_busy, frame_done, state}), 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    wu = 0; busy = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (write_uart) wu++;
      if (frame_busy || frame_done) busy++;
    end
    check("idle_pushes", wu, 0);
    check("idle_busy", busy, 0);
    check("idle_state", 32'({state, pix_addr, tx_data}), 0);

    foreach (vecs[k]) run_frame(vecs[k]);

    // Abort in WAIT_DATA of pixel 30
    fill(0);
    rx_q.delete(); done_cnt = 0; guard = 0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    while (!(state == 3'd3 && pix_addr == 6'd30) && guard < 500) begin
      tick();
      guard++;
    end
    check("abort_reach", guard < 500, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 32'(frame_busy), 0);
    check("abort_idle", 32'({state, pix_addr, write_uart}), 0);
    check("abort_pushes", rx_q.size(), 31);
    repeat (60) tick();
    check("abort_after", rx_q.size(), 31);
    check("abort_nodone", done_cnt, 0);
    run_frame(vecs[0]);

    // abort and frame_start together in IDLE
    rx_q.delete();
    frame_start = 1'b1; abort = 1'b1;
    tick();
    frame_start = 1'b0; abort = 1'b0;
    check("abort_start_state", 32'({state, frame_busy}), 0);
    repeat (10) tick();
    check("abort_start_push", rx_q.size(), 0);

    // Asynchronous reset mid-frame
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (50) tick();
    #3 reset_n = 1'b0;
    #1;
    check("async_reset_outs", 32'({pix_rd_en, pix_addr, write_uart, tx_data, frame_busy, frame_done, state}), 0);
    tick();
    reset_n = 1'b1;
    rx_q.delete(); done_cnt = 0;
    repeat (20) tick();
    check("post_reset_quiet", rx_q.size() + done_cnt + frame_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
